// File: rtl/cla_pkg.sv
// Shared defaults, operation encoding and the lookahead carry helper for the
// pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH  = 32;
    localparam int CLA_GROUP  = 4;
    localparam int CLA_STAGES = 2;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } cla_op_e;

    function automatic int cla_chunk(input int width, input int stages);
        return width / stages;
    endfunction

    // Carry into position j as a flat sum of products over generate/propagate
    // terms, so no carry ever ripples through a previous position's result.
    function automatic logic cla_carry(input logic [63:0] g, input logic [63:0] p,
                                       input logic cin, input int j);
        logic acc;
        logic term;
        acc = cin;
        for (int m = 0; m < j; m++) acc = acc & p[m];
        for (int i = 0; i < j; i++) begin
            term = g[i];
            for (int m = i + 1; m < j; m++) term = term & p[m];
            acc = acc | term;
        end
        return acc;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle of cla_pipe_adder. ovf exists only when
// CLA_OVF_EN is defined.
interface cla_pipe_adder_if import cla_pkg::*; #(
    parameter int WIDTH = CLA_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             G;
    logic             P;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, x, y, c_in, sub, out_ready,
`ifdef CLA_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, c_out, G, P
    );

    modport slave (
        input  in_valid, x, y, c_in, sub, out_ready,
`ifdef CLA_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, c_out, G, P
    );
endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: sum plus group generate and
// group propagate (the latter two independent of cin).
module cla_group import cla_pkg::*; #(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             g,
    output logic             p
);
    logic [GROUP-1:0] bg_s;
    logic [GROUP-1:0] bp_s;
    logic [GROUP-1:0] c_s;

    assign bg_s = a & b;
    assign bp_s = a ^ b;

    // per-bit carries from the flat lookahead equations
    always_comb begin
        c_s = {GROUP{1'b0}};
        for (int j = 0; j < GROUP; j++) begin
            c_s[j] = cla_carry(64'(bg_s), 64'(bp_s), cin, j);
        end
    end

    assign s = bp_s ^ c_s;
    assign g = cla_carry(64'(bg_s), 64'(bp_s), 1'b0, GROUP);
    assign p = &bp_s;
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES chunk per stage,
// chunk carry registered between stages. Optional signed overflow: CLA_OVF_EN.
module cla_pipe_adder import cla_pkg::*; #(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int GROUP  = CLA_GROUP,
    parameter int STAGES = CLA_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_pipe_adder_if.slave    bus
);
    localparam int CW = cla_chunk(WIDTH, STAGES);
    localparam int NG = CW / GROUP;
    localparam int L  = STAGES - 1;

    if ((WIDTH % (GROUP * STAGES)) != 0 || STAGES < 1 || STAGES > WIDTH / GROUP) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES and 1 <= STAGES <= WIDTH/GROUP");
    end

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] rdy_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_in_s, cin_s, g_in_s, p_in_s;
        logic [WIDTH-1:0] x_in_s, y_in_s, sum_in_s;
        logic [NG-1:0]    gg_s, gp_s;
        logic [NG:0]      gc_s;
        logic [CW-1:0]    cs_s;
        logic             chunk_g_s, chunk_p_s;
        logic             vld_q, cry_q, g_q, p_q;
        logic [WIDTH-1:0] x_q, y_q, sum_q;
        logic             cry_d, g_d, p_d;
        logic [WIDTH-1:0] x_d, y_d, sum_d;

        // A stage can load when it or anything downstream of it has room.
        assign vld_s[k] = vld_q;
        assign rdy_s[k] = bus.out_ready | ~(&vld_s[L:k]);

        if (k == 0) begin : g_head
            assign vld_in_s = bus.in_valid;
            assign x_in_s   = bus.x;
            assign y_in_s   = (bus.sub == OP_SUB) ? ~bus.y : bus.y;
            assign cin_s    = (bus.sub == OP_SUB) ? 1'b1 : bus.c_in;
            assign sum_in_s = {WIDTH{1'b0}};
            assign g_in_s   = 1'b0;
            assign p_in_s   = 1'b1;
        end else begin : g_body
            assign vld_in_s = g_stage[k-1].vld_q;
            assign x_in_s   = g_stage[k-1].x_q;
            assign y_in_s   = g_stage[k-1].y_q;
            assign cin_s    = g_stage[k-1].cry_q;
            assign sum_in_s = g_stage[k-1].sum_q;
            assign g_in_s   = g_stage[k-1].g_q;
            assign p_in_s   = g_stage[k-1].p_q;
        end

        // Operands are kept shifted so the current chunk is always the low CW bits.
        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a   (x_in_s[j*GROUP +: GROUP]),
                .b   (y_in_s[j*GROUP +: GROUP]),
                .cin (gc_s[j]),
                .s   (cs_s[j*GROUP +: GROUP]),
                .g   (gg_s[j]),
                .p   (gp_s[j])
            );
        end

        // second-level lookahead across the groups of this chunk
        always_comb begin
            gc_s = {(NG+1){1'b0}};
            for (int j = 0; j <= NG; j++) begin
                gc_s[j] = cla_carry(64'(gg_s), 64'(gp_s), cin_s, j);
            end
        end

        assign chunk_g_s = cla_carry(64'(gg_s), 64'(gp_s), 1'b0, NG);
        assign chunk_p_s = &gp_s;

        // next-state for this stage's register bank
        always_comb begin
            sum_d             = sum_in_s;
            sum_d[k*CW +: CW] = cs_s;
            x_d               = x_in_s >> CW;
            y_d               = y_in_s >> CW;
            cry_d             = gc_s[NG];
            g_d               = chunk_g_s | (chunk_p_s & g_in_s);
            p_d               = p_in_s & chunk_p_s;
        end

        // stage bank; data only loads with a valid beat so bubbles leave it untouched
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                g_q   <= 1'b0;
                p_q   <= 1'b0;
                x_q   <= {WIDTH{1'b0}};
                y_q   <= {WIDTH{1'b0}};
                sum_q <= {WIDTH{1'b0}};
            end else if (rdy_s[k]) begin
                vld_q <= vld_in_s;
                if (vld_in_s) begin
                    cry_q <= cry_d;
                    g_q   <= g_d;
                    p_q   <= p_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    sum_q <= sum_d;
                end
            end
        end
    end

    logic unused_ops_s;
    assign unused_ops_s = ^{g_stage[L].x_q, g_stage[L].y_q};

    assign bus.in_ready  = rdy_s[0];
    assign bus.out_valid = g_stage[L].vld_q;
    assign bus.sum       = g_stage[L].sum_q;
    assign bus.c_out     = g_stage[L].cry_q;
    assign bus.G         = g_stage[L].g_q;
    assign bus.P         = g_stage[L].p_q;

`ifdef CLA_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // carry into the MSB recovered as a ^ b ^ s at that bit
    assign ovf_d = g_stage[L].cry_d ^ g_stage[L].x_in_s[CW-1]
                 ^ g_stage[L].y_in_s[CW-1] ^ g_stage[L].cs_s[CW-1];

    // overflow flag registered alongside the final stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (rdy_s[L] && g_stage[L].vld_in_s) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (32/4/2); ovf is checked
// when CLA_OVF_EN is defined.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   errors   = 0;
    int   received = 0;
    int   accepted = 0;
    int   v        = 0;
    bit   acc;
    logic [35:0] exp_q [$];

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] observed();
        logic o;
`ifdef CLA_OVF_EN
        o = bus.ovf;
`else
        o = 1'b0;
`endif
        return {o, bus.G, bus.P, bus.c_out, bus.sum};
    endfunction

    // reference: plain wide addition; word generate is the carry-out with cin=0
    function automatic logic [35:0] model(input logic [31:0] xv, input logic [31:0] yv,
                                          input logic ci, input logic sb);
        logic [31:0] ye;
        logic [32:0] t;
        logic [32:0] t0;
        logic        o;
        ye = sb ? ~yv : yv;
        t  = {1'b0, xv} + {1'b0, ye} + {32'd0, sb ? 1'b1 : ci};
        t0 = {1'b0, xv} + {1'b0, ye};
        o  = (xv[31] == ye[31]) && (t[31] != xv[31]);
`ifndef CLA_OVF_EN
        o  = 1'b0;
`endif
        return {o, t0[32], &(xv ^ ye), t[32], t[31:0]};
    endfunction

    task automatic drive_vec(input int n);
        logic [31:0] a;
        a       = 32'h9E3779B9 * n;
        bus.x   = a;
        bus.y   = {a[15:0], a[31:16]} ^ (32'h01010101 * n);
        bus.sub = n[0];
        bus.c_in = n[1];
    endtask

    task automatic sb(output bit got);
        got = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'(1'b1));
            if (exp_q.size() != 0) chk("sb_result", 64'(observed()), 64'(exp_q.pop_front()));
            received++;
        end
        if (got) exp_q.push_back(model(bus.x, bus.y, bus.c_in, bus.sub));
    endtask

    // one beat into an empty pipe; checks handshake, two-cycle latency and result
    task automatic directed(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                            input logic ci, input logic sbv, input logic [31:0] es,
                            input logic ec, input logic eg, input logic ep, input logic eo);
        logic [35:0] e;
        e = {eo, eg, ep, ec, es};
`ifndef CLA_OVF_EN
        e[35] = 1'b0;
`endif
        bus.x = xv; bus.y = yv; bus.c_in = ci; bus.sub = sbv; bus.in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 64'(bus.out_valid), 64'(1'b0));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
        chk({tag, "_result"}, 64'(observed()), 64'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.x = 32'd0; bus.y = 32'd0; bus.c_in = 1'b0; bus.sub = 1'b0;
        #7;
        chk("reset_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("reset_outputs", 64'(observed()), 64'(36'd0));
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'(1'b1));

        // T1-T3 and extra corners, expected values worked by hand
        directed("t1_wrap", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("t2_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("t2_sub", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sub_cin_ign", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("t3_boundary", 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("sub_noborrow", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        directed("cin_only", 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // T4: 100 back-to-back beats
        received = 0;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                drive_vec(c);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t4_in_ready", 64'(bus.in_ready), 64'(1'b1));
            chk("t4_out_valid", 64'(bus.out_valid), 64'(c >= 2));
            sb(acc);
            @(posedge clk); #1;
        end
        chk("t4_count", 64'(received), 64'(100));
        chk("t4_drained", 64'(exp_q.size()), 64'(0));

        // T5: backpressure for 5 cycles with a continuous source
        received = 0; accepted = 0; v = 200;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) bus.out_ready = 1'b1;
            drive_vec(v);
            @(negedge clk);
            if (c < 5) begin
                chk("t5_in_ready", 64'(bus.in_ready), 64'(c < 2));
                if (c >= 2) begin
                    chk("t5_held_valid", 64'(bus.out_valid), 64'(1'b1));
                    chk("t5_held_result", 64'(observed()), 64'(exp_q[0]));
                end
            end else if (c == 5) begin
                chk("t5_release_ready", 64'(bus.in_ready), 64'(1'b1));
            end
            sb(acc);
            @(posedge clk); #1;
            if (acc) begin
                v++;
                accepted++;
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sb(acc);
            @(posedge clk); #1;
        end
        chk("t5_accepted", 64'(accepted), 64'(6));
        chk("t5_no_loss", 64'(received), 64'(accepted));
        chk("t5_drained", 64'(exp_q.size()), 64'(0));

        // T6: asynchronous reset mid-stream
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_vec(300 + c);
            @(negedge clk);
            sb(acc);
            @(posedge clk); #1;
        end
        chk("t6_in_flight", 64'(bus.out_valid), 64'(1'b1));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("t6_rst_outputs", 64'(observed()), 64'(36'd0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready_after", 64'(bus.in_ready), 64'(1'b1));
        chk("t6_no_ghost", 64'(bus.out_valid), 64'(1'b0));
        directed("t6_post_beat", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
